// File: rtl/acc_attitude_pre.sv
// Accelerometer pre-processing: per-axis offset/gain, squaring, and cross-axis radicands.
// One shared multiplier is time-multiplexed across six FSM states.
module acc_attitude_pre #(
    parameter int unsigned W    = 16,
    parameter int unsigned FRAC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_addr,
    input  logic [W-1:0]          cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [W-1:0]   acc_x,
    input  logic signed [W-1:0]   acc_y,
    input  logic signed [W-1:0]   acc_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*W-1:0] roll_sq,
    output logic signed [2*W-1:0] pitch_sq,
    output logic signed [2*W-1:0] yaw_sq,
    output logic [2*W-1:0]        norm_sq,
    output logic                  sat
);

    localparam logic [W-1:0] GainOne = {{(W-1){1'b0}}, 1'b1} << FRAC;

    typedef enum logic [3:0] {
        StIdle, StAdd, StScl0, StScl1, StScl2, StSq0, StSq1, StSq2, StDiff, StDone
    } state_e;

    state_e state_q;

    logic signed [W-1:0] cfg_off_q  [3];
    logic [W-1:0]        cfg_gain_q [3];

    logic signed [W-1:0] raw_q  [3];
    logic signed [W-1:0] off_q  [3];
    logic [W-1:0]        gain_q [3];
    logic signed [W:0]   t_q    [3];
    logic signed [W-1:0] c_q    [3];
    logic [2*W-1:0]      s_q    [3];
    logic                sat_acc_q;

    logic signed [W:0]     mul_a, mul_b;
    logic signed [2*W+1:0] mul_p;
    logic signed [2*W+1:0] scl_shift;
    logic                  scl_clip;
    logic signed [W-1:0]   scl_c;
    logic [2*W-1:0]        sq;

    // Config registers are independent of the FSM; samples see them only via the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                cfg_off_q[i]  <= '0;
                cfg_gain_q[i] <= GainOne;
            end
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0: cfg_off_q[0]  <= cfg_data;
                3'd1: cfg_off_q[1]  <= cfg_data;
                3'd2: cfg_off_q[2]  <= cfg_data;
                3'd3: cfg_gain_q[0] <= cfg_data;
                3'd4: cfg_gain_q[1] <= cfg_data;
                3'd5: cfg_gain_q[2] <= cfg_data;
                default: ;
            endcase
        end
    end

    // Multiplier operand binding per scheduled state.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            StScl0: begin mul_a = t_q[0]; mul_b = {1'b0, gain_q[0]}; end
            StScl1: begin mul_a = t_q[1]; mul_b = {1'b0, gain_q[1]}; end
            StScl2: begin mul_a = t_q[2]; mul_b = {1'b0, gain_q[2]}; end
            StSq0:  begin mul_a = {c_q[0][W-1], c_q[0]}; mul_b = mul_a; end
            StSq1:  begin mul_a = {c_q[1][W-1], c_q[1]}; mul_b = mul_a; end
            StSq2:  begin mul_a = {c_q[2][W-1], c_q[2]}; mul_b = mul_a; end
            default: ;
        endcase
    end

    assign mul_p     = mul_a * mul_b;
    assign scl_shift = mul_p >>> FRAC;
    // In range iff every bit from the W-1 position upward matches the sign.
    assign scl_clip  = scl_shift[2*W+1:W-1] != {(W+3){scl_shift[2*W+1]}};
    assign scl_c     = scl_clip ? {scl_shift[2*W+1], {(W-1){~scl_shift[2*W+1]}}}
                                : scl_shift[W-1:0];
    assign sq        = mul_p[2*W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            roll_sq   <= '0;
            pitch_sq  <= '0;
            yaw_sq    <= '0;
            norm_sq   <= '0;
            sat       <= 1'b0;
            sat_acc_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                raw_q[i]  <= '0;
                off_q[i]  <= '0;
                gain_q[i] <= '0;
                t_q[i]    <= '0;
                c_q[i]    <= '0;
                s_q[i]    <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        raw_q[0]  <= acc_x;
                        raw_q[1]  <= acc_y;
                        raw_q[2]  <= acc_z;
                        for (int i = 0; i < 3; i++) begin
                            off_q[i]  <= cfg_off_q[i];
                            gain_q[i] <= cfg_gain_q[i];
                        end
                        sat_acc_q <= 1'b0;
                        in_ready  <= 1'b0;
                        state_q   <= StAdd;
                    end
                end
                StAdd: begin
                    for (int i = 0; i < 3; i++) begin
                        t_q[i] <= {raw_q[i][W-1], raw_q[i]} + {off_q[i][W-1], off_q[i]};
                    end
                    state_q <= StScl0;
                end
                StScl0: begin
                    c_q[0]    <= scl_c;
                    sat_acc_q <= sat_acc_q | scl_clip;
                    state_q   <= StScl1;
                end
                StScl1: begin
                    c_q[1]    <= scl_c;
                    sat_acc_q <= sat_acc_q | scl_clip;
                    state_q   <= StScl2;
                end
                StScl2: begin
                    c_q[2]    <= scl_c;
                    sat_acc_q <= sat_acc_q | scl_clip;
                    state_q   <= StSq0;
                end
                StSq0: begin
                    s_q[0]  <= sq;
                    state_q <= StSq1;
                end
                StSq1: begin
                    s_q[1]  <= sq;
                    state_q <= StSq2;
                end
                StSq2: begin
                    s_q[2]  <= sq;
                    state_q <= StDiff;
                end
                StDiff: begin
                    // Squares are below 2^(2W-2), so neither differences nor the sum overflow.
                    roll_sq   <= s_q[2] - s_q[0];
                    pitch_sq  <= s_q[1] - s_q[2];
                    yaw_sq    <= s_q[0] - s_q[1];
                    norm_sq   <= s_q[0] + s_q[1] + s_q[2];
                    sat       <= sat_acc_q;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
